// File: rtl/booth_mult_pipe_if.sv
// Handshake bundle for booth_mult_pipe: operand side (in_*, a, b, alu_signed) and result side (out_*, prod, flags).
// Ports: in_valid/in_ready + a, b, alu_signed (operands); out_valid/out_ready + prod, neg_flag, zero_flag (result).
// master = issue/writeback side driving operands and out_ready; slave = the multiplier.
interface booth_mult_pipe_if #(
   parameter int WIDTH = 16
);
   localparam int PW = 2 * WIDTH;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             alu_signed;
   logic             out_valid;
   logic             out_ready;
   logic [PW-1:0]    prod;
   logic             neg_flag;
   logic             zero_flag;

   modport master (
      output in_valid, a, b, alu_signed, out_ready,
      input  in_ready, out_valid, prod, neg_flag, zero_flag
   );

   modport slave (
      input  in_valid, a, b, alu_signed, out_ready,
      output in_ready, out_valid, prod, neg_flag, zero_flag
   );
endinterface

// File: rtl/booth_mult_pipe.sv
// Pipelined radix-4 Booth multiplier, full 2*WIDTH product, signed or unsigned per op.
// Latency 3 cycles (encode / carry-save reduce / final add), throughput 1 per cycle.
// Backpressure ripples back combinationally through per-stage ready; flush clears all valids.
// Ports: clk, rst_n (async active-low), flush (sync clear), bus (slave side of booth_mult_pipe_if).
// The interface instance must be built with the same WIDTH as this module.
module booth_mult_pipe #(
   parameter  int WIDTH = 16,
   localparam int PW    = 2 * WIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   booth_mult_pipe_if.slave    bus
);
   localparam int N  = WIDTH / 2 + 1;   // Booth digits / partial products
   localparam int EW = WIDTH + 2;       // extended operand width

   // ---------------- flow control ----------------
   logic v1, v2, v3;
   logic rdy1, rdy2, rdy3;

   assign rdy3         = !v3 || bus.out_ready;
   assign rdy2         = !v2 || rdy3;
   assign rdy1         = !v1 || rdy2;
   assign bus.in_ready = rdy1 && !flush;
   assign bus.out_valid = v3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else if (flush) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         if (rdy1) v1 <= bus.in_valid;
         if (rdy2) v2 <= v1;
         if (rdy3) v3 <= v2;
      end
   end

   // ---------------- S1: Booth encode ----------------
   logic [EW-1:0] a_ext, b_ext;
   logic [PW-1:0] a_pw;
   logic [EW:0]   b_win;   // multiplier with the implicit 0 below bit 0
   logic [PW-1:0] pp_c [N];
   logic [N-1:0]  corr_c;

   assign a_ext = bus.alu_signed ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
   assign b_ext = bus.alu_signed ? {{2{bus.b[WIDTH-1]}}, bus.b} : {2'b00, bus.b};
   assign a_pw  = {{(PW-EW){a_ext[EW-1]}}, a_ext};
   assign b_win = {b_ext, 1'b0};

   always_comb begin
      for (int i = 0; i < N; i++) begin
         logic [PW-1:0] mag;
         logic          neg;
         mag = '0;
         neg = 1'b0;
         case (b_win[2*i +: 3])
            3'b001, 3'b010: mag = a_pw;
            3'b011:         mag = a_pw << 1;
            3'b100: begin   mag = a_pw << 1; neg = 1'b1; end
            3'b101, 3'b110: begin mag = a_pw; neg = 1'b1; end
            default:        mag = '0;   // 000 / 111 -> zero digit
         endcase
         // Invert before shifting so the vacated low bits stay 0; the +1 sits at bit 2i.
         pp_c[i]   = (neg ? ~mag : mag) << (2 * i);
         corr_c[i] = neg;
      end
   end

   logic [PW-1:0] s1_pp [N];
   logic [N-1:0]  s1_corr;
   logic          s1_signed;

   always_ff @(posedge clk) begin
      if (rdy1 && bus.in_valid) begin
         s1_pp     <= pp_c;
         s1_corr   <= corr_c;
         s1_signed <= bus.alu_signed;
      end
   end

   // ---------------- S2: carry-save reduction ----------------
   function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] x, y, z);
      return {x ^ y ^ z, (x & y) | (x & z) | (y & z)};
   endfunction

   logic [PW-1:0] corr_row;
   logic [PW-1:0] sum_c, carry_c;   // value = sum_c + (carry_c << 1)

   always_comb begin
      corr_row = '0;
      for (int i = 0; i < N; i++) corr_row[2*i] = s1_corr[i];
      sum_c   = s1_pp[0];
      carry_c = '0;
      for (int i = 1; i < N; i++)
         {sum_c, carry_c} = csa(sum_c, carry_c << 1, s1_pp[i]);
      {sum_c, carry_c} = csa(sum_c, carry_c << 1, corr_row);
   end

   logic [PW-1:0] s2_sum, s2_carry;
   logic          s2_signed;

   always_ff @(posedge clk) begin
      if (rdy2 && v1) begin
         s2_sum    <= sum_c;
         s2_carry  <= carry_c;
         s2_signed <= s1_signed;
      end
   end

   // ---------------- S3: final carry-propagate add ----------------
   logic [PW-1:0] prod_c;
   logic [PW-1:0] prod_q;
   logic          neg_q, zero_q;

   assign prod_c = s2_sum + (s2_carry << 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= '0;
         neg_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (!flush && rdy3 && v2) begin
         prod_q <= prod_c;
         neg_q  <= s2_signed & prod_c[PW-1];
         zero_q <= (prod_c == '0);
      end
   end

   assign bus.prod      = prod_q;
   assign bus.neg_flag  = neg_q;
   assign bus.zero_flag = zero_q;
endmodule

// File: tb/tb_booth_mult_pipe.sv
module tb_booth_mult_pipe;
   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   always #5 clk = ~clk;

   booth_mult_pipe_if #(.WIDTH(16)) bus ();

   booth_mult_pipe #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   // Reference: {prod, neg_flag, zero_flag} from plain integer multiply.
   function automatic logic [33:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input logic s);
      longint      p;
      logic [31:0] r;
      if (s) p = longint'($signed(x)) * longint'($signed(y));
      else   p = longint'(x) * longint'(y);
      r = p[31:0];
      return {r, s & r[31], r == 32'd0};
   endfunction

   function automatic logic [15:0] pick_op();
      case ($urandom_range(7))
         0:       return 16'h8000;
         1:       return 16'hFFFF;
         2:       return 16'h0000;
         3:       return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.alu_signed = 1'b0; bus.out_ready = 1'b1;
      #12;
      total_cnt++;
      if ({bus.out_valid, bus.prod, bus.neg_flag, bus.zero_flag} !== 35'd0) $display("FAIL reset_outputs: got %h expected 0", {bus.out_valid, bus.prod, bus.neg_flag, bus.zero_flag});
      else pass_cnt++;
      #6 rst_n = 1'b1;
      tick();
      total_cnt++;
      if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      else pass_cnt++;
   endtask

   task automatic test_vector(input string name, input logic [15:0] x, input logic [15:0] y, input logic s,
                              input logic [31:0] ep, input logic en, input logic ez);
      bus.out_ready = 1'b1;
      bus.a = x; bus.b = y; bus.alu_signed = s; bus.in_valid = 1'b1;
      #1;
      total_cnt++;
      if (bus.in_ready !== 1'b1) $display("FAIL %s_in_ready: got %b expected 1", name, bus.in_ready);
      else pass_cnt++;
      tick();
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
      tick();
      total_cnt++;
      if (bus.out_valid !== 1'b0) $display("FAIL %s_early_valid: got %b expected 0", name, bus.out_valid);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({bus.out_valid, bus.prod, bus.neg_flag, bus.zero_flag} !== {1'b1, ep, en, ez})
         $display("FAIL %s_result: got v=%b p=%h n=%b z=%b expected v=1 p=%h n=%b z=%b", name,
                  bus.out_valid, bus.prod, bus.neg_flag, bus.zero_flag, ep, en, ez);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.out_valid !== 1'b0) $display("FAIL %s_drain: got %b expected 0", name, bus.out_valid);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] va [10];
      logic [15:0] vb [10];
      logic        vs [10];
      logic [33:0] expq [$];
      logic [33:0] held;
      int issued = 0, got = 0;
      for (int i = 0; i < 10; i++) begin
         va[i] = pick_op(); vb[i] = pick_op(); vs[i] = 1'($urandom_range(1));
      end
      for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
         bus.out_ready = !(cyc >= 4 && cyc <= 8);
         bus.in_valid  = (issued < 10);
         if (issued < 10) begin
            bus.a = va[issued]; bus.b = vb[issued]; bus.alu_signed = vs[issued];
         end
         #1;
         if (cyc == 4) held = {bus.prod, bus.neg_flag, bus.zero_flag};
         if (cyc == 5) begin
            total_cnt++;
            if (bus.in_ready !== 1'b0) $display("FAIL b2b_in_ready_full: got %b expected 0", bus.in_ready);
            else pass_cnt++;
         end
         if (cyc >= 5 && cyc <= 8) begin
            total_cnt++;
            if ({bus.out_valid, bus.prod, bus.neg_flag, bus.zero_flag} !== {1'b1, held})
               $display("FAIL b2b_stall_hold: cycle %0d got v=%b %h expected v=1 %h", cyc, bus.out_valid,
                        {bus.prod, bus.neg_flag, bus.zero_flag}, held);
            else pass_cnt++;
         end
         if (bus.in_valid && bus.in_ready) begin
            expq.push_back(ref_mul(bus.a, bus.b, bus.alu_signed));
            issued++;
         end
         if (bus.out_valid && bus.out_ready) begin
            total_cnt++;
            if (expq.size() == 0) $display("FAIL b2b_result: got unexpected output %h expected none", bus.prod);
            else begin
               logic [33:0] e;
               e = expq.pop_front();
               if ({bus.prod, bus.neg_flag, bus.zero_flag} !== e)
                  $display("FAIL b2b_result: result %0d got %h expected %h", got, {bus.prod, bus.neg_flag, bus.zero_flag}, e);
               else pass_cnt++;
            end
            got++;
         end
         tick();
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      total_cnt++;
      if (got !== 10) $display("FAIL b2b_count: got %0d expected 10", got);
      else pass_cnt++;
   endtask

   task automatic test_flush();
      logic [33:0] e0;
      logic [31:0] p_hold;
      int seen = 0;
      bus.out_ready = 1'b1;
      e0 = ref_mul(16'd100, 16'd3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1; bus.a = 16'd100 + 16'(i); bus.b = 16'd3; bus.alu_signed = 1'b0;
         tick();
      end
      // three ops in flight, oldest now presented on the output
      bus.out_ready = 1'b0; flush = 1'b1; bus.a = 16'd9; bus.b = 16'd9;
      #1;
      total_cnt++;
      if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b expected 0", bus.in_ready);
      else pass_cnt++;
      total_cnt++;
      if ({bus.out_valid, bus.prod, bus.neg_flag, bus.zero_flag} !== {1'b1, e0})
         $display("FAIL flush_pre_out: got v=%b %h expected v=1 %h", bus.out_valid, {bus.prod, bus.neg_flag, bus.zero_flag}, e0);
      else pass_cnt++;
      p_hold = e0[33:2];
      tick();
      flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      #1;
      total_cnt++;
      if ({bus.out_valid, bus.prod} !== {1'b0, p_hold})
         $display("FAIL flush_cleared: got v=%b p=%h expected v=0 p=%h", bus.out_valid, bus.prod, p_hold);
      else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
         if (bus.out_valid) seen++;
         tick();
      end
      total_cnt++;
      if (seen !== 0) $display("FAIL flush_no_results: got %0d outputs expected 0", seen);
      else pass_cnt++;
      test_vector("post_flush", 16'd12, 16'd11, 1'b0, 32'd132, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1; bus.a = 16'd3; bus.b = 16'd7; bus.alu_signed = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      total_cnt++;
      if ({bus.out_valid, bus.prod} !== {1'b1, 32'd21}) $display("FAIL arst_pre: got v=%b p=%h expected v=1 p=15", bus.out_valid, bus.prod);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({bus.out_valid, bus.prod, bus.neg_flag, bus.zero_flag} !== 35'd0)
         $display("FAIL arst_immediate: got %h expected 0", {bus.out_valid, bus.prod, bus.neg_flag, bus.zero_flag});
      else pass_cnt++;
      #2 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      total_cnt++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) $display("FAIL arst_release: got rdy=%b v=%b expected rdy=1 v=0", bus.in_ready, bus.out_valid);
      else pass_cnt++;
   endtask

   task automatic test_random(input int n);
      logic [33:0] expq [$];
      logic [33:0] prev_val;
      logic        prev_stall = 1'b0;
      int issued = 0, got = 0;
      for (int cyc = 0; cyc < 4000 && got < n; cyc++) begin
         bus.in_valid = (issued < n) && ($urandom_range(3) != 0);
         bus.a = pick_op(); bus.b = pick_op(); bus.alu_signed = 1'($urandom_range(1));
         bus.out_ready = ($urandom_range(9) < 7);
         #1;
         if (prev_stall) begin
            total_cnt++;
            if ({bus.out_valid, bus.prod, bus.neg_flag, bus.zero_flag} !== {1'b1, prev_val})
               $display("FAIL rand_stall_hold: got v=%b %h expected v=1 %h", bus.out_valid, {bus.prod, bus.neg_flag, bus.zero_flag}, prev_val);
            else pass_cnt++;
         end
         if (bus.in_valid && bus.in_ready) begin
            expq.push_back(ref_mul(bus.a, bus.b, bus.alu_signed));
            issued++;
         end
         if (bus.out_valid && bus.out_ready) begin
            total_cnt++;
            if (expq.size() == 0) $display("FAIL rand_result: got unexpected output %h expected none", bus.prod);
            else begin
               logic [33:0] e;
               e = expq.pop_front();
               if ({bus.prod, bus.neg_flag, bus.zero_flag} !== e)
                  $display("FAIL rand_result: result %0d got %h expected %h", got, {bus.prod, bus.neg_flag, bus.zero_flag}, e);
               else pass_cnt++;
            end
            got++;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_val   = {bus.prod, bus.neg_flag, bus.zero_flag};
         tick();
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      total_cnt++;
      if (got !== n) $display("FAIL rand_count: got %0d expected %0d", got, n);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_vector("s_neg3x5",     16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, 1'b1, 1'b0);
      test_vector("u_ones",       16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b0, 1'b0);
      test_vector("s_ones",       16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 1'b0, 1'b0);
      test_vector("s_minxmin",    16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b0, 1'b0);
      test_vector("s_zero",       16'h1234, 16'h0000, 1'b1, 32'h00000000, 1'b0, 1'b1);
      test_vector("s_maxxmin",    16'h7FFF, 16'h8000, 1'b1, 32'hC0008000, 1'b1, 1'b0);
      test_vector("u_8000x2",     16'h8000, 16'h0002, 1'b0, 32'h00010000, 1'b0, 1'b0);
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_random(300);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/booth_mult_pipe.md
Name: booth_mult_pipe

Overview:
- Parametrised, pipelined radix-4 Booth multiplier; successor to the combinational 16x16 Booth/tree/CLA multiplier.
- Generalised to any even operand width and returns the full 2*WIDTH product.
- Three registered stages (Booth encode, CSA reduction, final CPA) with valid/ready handshake on both sides, backpressure and synchronous flush.
- Sits between the ALU issue logic and the writeback mux.

Parameters:
- WIDTH, 16, operand width; even, 4..64.
- PW, 2*WIDTH, product width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline clear
- in_valid  input  1  operand handshake valid
- in_ready  output  1  operand handshake ready
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- alu_signed  input  1  1 = two's-complement operands, 0 = unsigned
- out_valid  output  1  result handshake valid
- out_ready  input  1  result handshake ready
- prod  output  PW  full product
- neg_flag  output  1  prod[PW-1] when signed op, else 0
- zero_flag  output  1  prod == 0

Behaviour:
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - a, b and alu_signed are sampled only on input transfer.
- Stage S1 (encode):
  - Operands extended to WIDTH+2 bits: sign-extended if alu_signed, else zero-extended.
  - Booth radix-4 encoding gives N = WIDTH/2+1 partial products, each PW bits, shifted 2i.
  - Negative PPs are formed as inverted value plus a correction bit.
  - All PPs, correction bits and alu_signed are registered with v1.
- Stage S2 (reduce):
  - 3:2 CSA tree reduces the PPs to sum and carry rows, each PW bits.
  - Sum, carry and alu_signed are registered with v2.
- Stage S3 (CPA):
  - prod = sum + (carry<<1), truncated to PW bits; carry-out discarded.
  - prod and flags are registered with v3 (v3 = out_valid).
- Latency: exactly 3 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle.
- Flow control per stage:
  - rdy3 = !v3 || out_ready
  - rdy2 = !v2 || rdy3
  - rdy1 = !v1 || rdy2
  - in_ready = rdy1, combinational.
  - Bubbles collapse.
  - A stalled stage holds its data and valid unchanged.
- Ordering: results leave in issue order; no reordering or drop except on flush.
- Stability: while out_valid && !out_ready, prod and both flags are held stable.
- Data registers are not reset (only valids); prod and flags are reset to 0.
- Reset:
  - rst_n low clears v1, v2, v3 immediately, regardless of clk.
  - out_valid = 0, prod = 0, neg_flag = 0, zero_flag = 0.
  - In-flight ops are lost.
  - in_ready = 1 the first cycle after release.
- flush:
  - On a clk edge with flush = 1, v1, v2 and v3 are cleared; prod is unchanged.
  - An input presented in the same cycle is not accepted: in_ready is forced 0 while flush = 1.
  - An output handshake in the same cycle still completes from the bench's view, but the result is discarded afterwards.
- Arithmetic boundaries:
  - Signed most-negative × most-negative yields the positive 2^(PW-2); no overflow in PW bits.
  - Unsigned all-ones × all-ones yields 2^PW − 2^(WIDTH+1) + 1.
- Simultaneous input and output transfer on a full pipeline sustains throughput with no bubble.

Test Plan:
- WIDTH=16, signed, a=0xFFFD (-3), b=0x0005 -> 3 cycles later prod=0xFFFFFFF1, neg_flag=1, zero_flag=0.
- Unsigned, a=0xFFFF, b=0xFFFF -> prod=0xFFFE0001, neg_flag=0. Signed with same operands -> prod=0x00000001.
- Signed, a=0x8000, b=0x8000 -> prod=0x40000000. Then a=0x1234, b=0x0000 -> prod=0, zero_flag=1.
- Back-to-back stream of 10 random ops with out_ready=0 for cycles 4..8:
  - in_ready drops after the pipe fills (3 held).
  - prod is stable during the stall.
  - All 10 results match the reference model, in order.
- flush asserted with 3 ops in flight -> out_valid=0 next cycle and none of those 3 results appear. The next op issues normally with 3-cycle latency.
- rst_n pulsed low mid-stream (asynchronously, between edges) -> out_valid and prod go 0 immediately. After release, the WIDTH=8 and WIDTH=32 builds pass 1000 random signed/unsigned ops each.
